// File: rtl/ahb_s_mem.sv
// AHB-Lite slave backed by a register-array memory.
// Pipelined address/data phases, programmable wait states and a two-cycle ERROR response.
module ahb_s_mem #(
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int AHB_ADDRESS_WIDTH = 32,
  parameter int MEM_DEPTH         = 256,
  parameter int WAIT_STATES       = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [AHB_ADDRESS_WIDTH-1:0] HADDR,
  input  logic [AHB_DATA_WIDTH-1:0]    HWDATA,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [2:0]                   HBURST,
  input  logic [1:0]                   HTRANS,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [AHB_DATA_WIDTH-1:0]    HRDATA
);
  localparam int NB = AHB_DATA_WIDTH / 8;
  localparam int LW = $clog2(NB);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t                    state, state_nxt;
  logic [3:0]                cnt;
  logic [IW-1:0]             a_idx;
  logic [LW-1:0]             a_lane;
  logic [2:0]                a_size;
  logic                      a_write;
  logic                      accept, bad;
  logic [NB-1:0]             be;
  logic [AHB_DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic                      unused_burst;

  assign unused_burst = ^HBURST;

  // Address phases are taken only in the states that drive HREADY high.
  assign accept = (state == S_IDLE || state == S_DONE || state == S_ERR2) && HTRANS[1];

  always_comb begin
    bad = 1'b0;
    if ((HADDR >> LW) >= AHB_ADDRESS_WIDTH'(MEM_DEPTH)) bad = 1'b1;
    if ((HADDR & ((AHB_ADDRESS_WIDTH'(1) << HSIZE) - AHB_ADDRESS_WIDTH'(1))) != '0) bad = 1'b1;
    if ((32'd8 << HSIZE) > 32'(AHB_DATA_WIDTH)) bad = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_idx   <= '0;
      a_lane  <= '0;
      a_size  <= '0;
      a_write <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= 4'(WAIT_STATES);
        a_idx   <= HADDR[LW +: IW];
        a_lane  <= HADDR[LW-1:0];
        a_size  <= HSIZE;
        a_write <= HWRITE;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAIT:  if (cnt <= 4'd1) state_nxt = S_DONE;
      S_ERR1:  state_nxt = S_ERR2;
      default: begin
        if (!accept)              state_nxt = S_IDLE;
        else if (bad)             state_nxt = S_ERR1;
        else if (WAIT_STATES > 0) state_nxt = S_WAIT;
        else                      state_nxt = S_DONE;
      end
    endcase
  end

  // Byte lanes touched by the sampled transfer.
  always_comb begin
    int lo, hi;
    lo = int'(a_lane);
    hi = lo + int'(32'd1 << a_size);
    be = '0;
    for (int b = 0; b < NB; b++) be[b] = (b >= lo) && (b < hi);
  end

  // Writes commit at the edge closing DONE, so a pipelined read sees them.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == S_DONE && a_write) begin
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[a_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    case (state)
      S_WAIT: HREADY = 1'b0;
      S_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      S_DONE: begin
        if (!a_write)
          for (int b = 0; b < NB; b++)
            if (be[b]) HRDATA[b*8 +: 8] = mem[a_idx][b*8 +: 8];
      end
      default: ;
    endcase
  end
endmodule
